alu_issue: RTL

- Sequencer that drives the `alu` block from the instruction side.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them into ALU control fields.
- Reads operands from an internal 16x32 register file and resolves the condition code against an architectural flags register.
- Writes the ALU result and flags back, then reports retirement. It sits between instruction fetch and the combinational ALU.

---
 rtl/alu_pkg.sv | 72 +++++++
 rtl/alu_cond_eval.sv | 41 ++++
 rtl/alu_issue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, condition codes,
// flag bit positions, instruction field positions and the FSM state type.
package alu_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_MOV   = 4'h6;
    localparam logic [3:0] OP_MOVI  = 4'h7;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_CMP   = 4'hB;

    // Condition codes
    localparam logic [3:0] COND_AL = 4'h0;
    localparam logic [3:0] COND_EQ = 4'h1;
    localparam logic [3:0] COND_NE = 4'h2;
    localparam logic [3:0] COND_CS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_MI = 4'h5;
    localparam logic [3:0] COND_PL = 4'h6;
    localparam logic [3:0] COND_VS = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_HI = 4'h9;
    localparam logic [3:0] COND_LS = 4'hA;
    localparam logic [3:0] COND_GE = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GT = 4'hD;
    localparam logic [3:0] COND_LE = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Flag bit indices inside {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Instruction field positions
    localparam int F_COND_MSB = 31;
    localparam int F_COND_LSB = 28;
    localparam int F_OP_MSB   = 27;
    localparam int F_OP_LSB   = 24;
    localparam int F_S        = 23;
    localparam int F_SRC_MSB  = 22;
    localparam int F_SRC_LSB  = 20;
    localparam int F_RD_MSB   = 19;
    localparam int F_RD_LSB   = 16;
    localparam int F_RN_MSB   = 15;
    localparam int F_RN_LSB   = 12;
    localparam int F_RM_MSB   = 11;
    localparam int F_RM_LSB   = 8;
    localparam int F_SRB_MSB  = 7;
    localparam int F_SRB_LSB  = 3;
    localparam int F_IMM_MSB  = 15;
    localparam int F_IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } issue_state_t;

    // Opcodes 1001, 1010 and 1100-1111 have no defined meaning
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'h9) || (op == 4'hA) || (op >= 4'hC);
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction
// with the given condition executes under the current {N,Z,C,V} flags.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Map each condition code onto its flag predicate
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue sequencer: accepts one instruction at a time, reads operands
// from a 16x32 register file, resolves the condition against the
// architectural flags, drives the external combinational ALU and writes the
// result back before reporting retirement.
// Optional build macro: ALU_ISSUE_PERF_CNT_EN adds retire/skip/illegal counters.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_opcode,
    output logic [3:0]    alu_cond,
    output logic          alu_s,
    output logic [2:0]    alu_sr_cont,
    output logic [4:0]    alu_sr_bit,
    output logic [15:0]   alu_imm,
    input  logic [DW-1:0] alu_out,
    input  logic [3:0]    alu_flags,
    output logic [3:0]    flags,
    output logic          retire_valid,
    output logic [3:0]    retire_rd,
    output logic [DW-1:0] retire_data,
    output logic          retire_skipped,
    output logic          retire_illegal,
`ifdef ALU_ISSUE_PERF_CNT_EN
    output logic [31:0]   perf_retired,
    output logic [31:0]   perf_skipped,
    output logic [31:0]   perf_illegal,
`endif
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    issue_state_t state, state_next;

    logic [31:0]   instr_q;
    logic [DW-1:0] regs [NREGS];
    logic [3:0]    flags_q;
    logic          skip_q;
    logic          illegal_q;

    logic [3:0]    f_cond;
    logic [3:0]    f_op;
    logic          f_s;
    logic [2:0]    f_src;
    logic [3:0]    f_rd;
    logic [3:0]    f_rn;
    logic [3:0]    f_rm;
    logic [4:0]    f_srb;
    logic [15:0]   f_imm;

    logic          cond_pass;
    logic          op_illegal;
    logic          wr_en;
    logic          flag_en;

    assign f_cond = instr_q[F_COND_MSB:F_COND_LSB];
    assign f_op   = instr_q[F_OP_MSB:F_OP_LSB];
    assign f_s    = instr_q[F_S];
    assign f_src  = instr_q[F_SRC_MSB:F_SRC_LSB];
    assign f_rd   = instr_q[F_RD_MSB:F_RD_LSB];
    assign f_rn   = instr_q[F_RN_MSB:F_RN_LSB];
    assign f_rm   = instr_q[F_RM_MSB:F_RM_LSB];
    assign f_srb  = instr_q[F_SRB_MSB:F_SRB_LSB];
    assign f_imm  = instr_q[F_IMM_MSB:F_IMM_LSB];

    assign op_illegal = is_illegal(f_op);

    alu_cond_eval u_cond_eval (
        .cond  (f_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    // Conditions are resolved here, so the ALU never sees one
    assign alu_cond = 4'b0000;
    assign flags    = flags_q;
    assign dbg_data = regs[dbg_addr];

    // Write-back qualifiers: only executed instructions touch architectural state
    assign wr_en   = (state == ST_WB) && !illegal_q && !skip_q && (f_op != OP_CMP);
    assign flag_en = (state == ST_WB) && !illegal_q && !skip_q && (f_s || (f_op == OP_CMP));

    assign retire_valid   = (state == ST_WB);
    assign retire_rd      = (state == ST_WB) ? f_rd : 4'd0;
    assign retire_data    = wr_en ? alu_out : '0;
    assign retire_skipped = (state == ST_WB) && skip_q && !illegal_q;
    assign retire_illegal = (state == ST_WB) && illegal_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; skipped and illegal instructions bypass EXEC
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_illegal || !cond_pass) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the instruction word on the accepting handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
        end else if (state == ST_IDLE && instr_valid) begin
            instr_q <= instr;
        end
    end

    // Decode: record skip/illegal status and register the ALU controls so they stay stable through EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q      <= 1'b0;
            illegal_q   <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_opcode  <= '0;
            alu_s       <= 1'b0;
            alu_sr_cont <= '0;
            alu_sr_bit  <= '0;
            alu_imm     <= '0;
        end else if (state == ST_DECODE) begin
            illegal_q <= op_illegal;
            skip_q    <= !op_illegal && !cond_pass;
            if (!op_illegal && cond_pass) begin
                alu_in1     <= regs[f_rn];
                alu_in2     <= regs[f_rm];
                alu_opcode  <= f_op;
                alu_s       <= f_s;
                alu_sr_cont <= f_src;
                alu_sr_bit  <= f_srb;
                alu_imm     <= f_imm;
            end
        end
    end

    // Write-back of the ALU result and flags at the end of WB
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            if (wr_en) begin
                regs[f_rd] <= alu_out;
            end
            if (flag_en) begin
                flags_q <= alu_flags;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_retired_q;
    logic [31:0] perf_skipped_q;
    logic [31:0] perf_illegal_q;

    assign perf_retired = perf_retired_q;
    assign perf_skipped = perf_skipped_q;
    assign perf_illegal = perf_illegal_q;

    // Free-running wrap-around counters of retirement outcomes
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired_q <= '0;
            perf_skipped_q <= '0;
            perf_illegal_q <= '0;
        end else if (retire_valid) begin
            perf_retired_q <= perf_retired_q + 32'd1;
            if (retire_skipped) begin
                perf_skipped_q <= perf_skipped_q + 32'd1;
            end
            if (retire_illegal) begin
                perf_illegal_q <= perf_illegal_q + 32'd1;
            end
        end
    end
`endif

endmodule
